grant_mux: RTL and testbench

Burst data mux downstream of the 3-way arbiter. It takes the arbiter's one-hot `grant` and latches the granted requester as burst owner. It then forwards that requester's data beats onto a single shared valid/ready output until the burst completes or stalls out. Grant changes during a burst are ignored, which keeps the shared resource from being handed off mid-transfer.

---
 rtl/grant_mux_pkg.sv | 17 +
 rtl/burst_counter.sv | 35 +++
 rtl/grant_mux.sv | 144 ++++++++++++++
 tb/tb_grant_mux.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_mux_pkg.sv
// Shared types and constants for the grant_mux burst data mux.
package grant_mux_pkg;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [NUM_REQ-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Saturating up-counter with synchronous clear and a compare against a terminal value.
module burst_counter
    import grant_mux_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             at_term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/grant_mux.sv
// Burst data mux: latches a one-hot grant as burst owner and forwards that
// requester's beats onto one shared valid/ready port until the burst ends.
module grant_mux
    import grant_mux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        grant,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        owner,
    output logic                      done,
    output logic                      aborted,
    output logic                      grant_err
);

    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 grant_err_q, grant_err_d;

    logic                 beat_clr, beat_inc, beat_term;
    logic                 stall_clr, stall_inc, stall_term;
    logic                 in_burst, owner_vld, xfer;

    assign in_burst  = (state_q == ST_BURST);
    assign owner_vld = |(req_valid & owner_q);
    assign out_valid = in_burst & owner_vld;
    assign xfer      = out_valid & out_ready;
    assign req_ready = in_burst ? (owner_q & {NUM_REQ{out_ready}}) : '0;

    always_comb begin
        out_data = '0;
        if (in_burst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q[i]) begin
                    out_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    burst_counter u_beat_cnt (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (beat_clr),
        .inc_i     (beat_inc),
        .term_i    (BEAT_LAST),
        .at_term_o (beat_term)
    );

    burst_counter u_stall_cnt (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (stall_clr),
        .inc_i     (stall_inc),
        .term_i    (STALL_LAST),
        .at_term_o (stall_term)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        aborted_d   = 1'b0;
        grant_err_d = 1'b0;
        beat_clr    = 1'b0;
        beat_inc    = 1'b0;
        stall_clr   = 1'b0;
        stall_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_onehot(grant) && (|(req_valid & grant))) begin
                    owner_d   = grant;
                    beat_clr  = 1'b1;
                    stall_clr = 1'b1;
                    state_d   = ST_BURST;
                end else if ((grant != '0) && !is_onehot(grant)) begin
                    grant_err_d = 1'b1;
                end
            end
            ST_BURST: begin
                // A valid owner cycle resets the stall run even if the sink stalls it.
                beat_inc  = xfer;
                stall_inc = ~owner_vld;
                stall_clr = owner_vld;
                if (xfer && beat_term) begin
                    state_d = ST_DONE;
                end else if (!owner_vld && stall_term) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign owner     = owner_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_grant_mux.sv
// Self-checking bench for grant_mux: transaction-level model plus directed scenarios.
module tb_grant_mux;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [2:0]          grant;
    logic [2:0]          req_valid;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          req_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_ready;
    logic                busy;
    logic [2:0]          owner;
    logic                done;
    logic                aborted;
    logic                grant_err;

    grant_mux #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .grant(grant), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .owner(owner),
        .done(done), .aborted(aborted), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = no burst, 1 = moving beats, 2 = end cycle.
    int         m_phase;
    int         m_taken;
    int         m_stall;
    logic [2:0] m_owner;
    logic       m_done, m_abort, m_gerr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_taken = 0; m_stall = 0; m_owner = 3'b000;
            m_done = 1'b0; m_abort = 1'b0; m_gerr = 1'b0;
        end else begin
            m_done = 1'b0; m_abort = 1'b0; m_gerr = 1'b0;
            if (m_phase == 0) begin
                if ($countones(grant) == 1 && (req_valid & grant) != 3'b000) begin
                    m_owner = grant; m_taken = 0; m_stall = 0; m_phase = 1;
                end else if (grant != 3'b000) begin
                    m_gerr = 1'b1;
                end
            end else if (m_phase == 1) begin
                if ((req_valid & m_owner) != 3'b000) begin
                    m_stall = 0;
                    if (out_ready) m_taken++;
                    if (m_taken == BURST_LEN) begin
                        m_phase = 2; m_done = 1'b1;
                    end
                end else begin
                    m_stall++;
                    if (m_stall == TIMEOUT) begin
                        m_phase = 2; m_done = 1'b1; m_abort = 1'b1;
                    end
                end
            end else begin
                m_phase = 0; m_owner = 3'b000;
            end
        end
    end

    // Per-cycle comparison and capture of what actually left the shared port.
    logic [7:0] cap[$];
    int         done_cnt = 0;
    int         gerr_cnt = 0;
    logic       last_abort;
    logic [2:0] last_owner;

    always @(negedge clk) begin
        logic             e_valid;
        logic [DATA_W-1:0] e_data;
        logic [2:0]       e_ready;
        e_valid = (m_phase == 1) && ((req_valid & m_owner) != 3'b000);
        e_data  = '0;
        if (m_phase == 1)
            for (int i = 0; i < 3; i++)
                if (m_owner[i]) e_data = req_data[i*DATA_W +: DATA_W];
        e_ready = (m_phase == 1) ? (m_owner & {3{out_ready}}) : 3'b000;
        chk("busy", busy, (m_phase != 0));
        chk("owner", owner, m_owner);
        chk("done", done, m_done);
        chk("aborted", aborted, m_abort);
        chk("grant_err", grant_err, m_gerr);
        chk("out_valid", out_valid, e_valid);
        chk("out_data", out_data, e_data);
        chk("req_ready", req_ready, e_ready);
        if (out_valid && out_ready) cap.push_back(out_data);
        if (done) begin
            done_cnt++; last_abort = aborted; last_owner = owner;
        end
        if (grant_err) gerr_cnt++;
    end

    // Source model: each requester emits base+index, index advancing on accept.
    int         src_base[3] = '{8'h01, 8'h11, 8'h21};
    int         src_idx[3];
    logic [2:0] fire;

    task automatic upd_data();
        for (int i = 0; i < 3; i++)
            req_data[i*DATA_W +: DATA_W] = DATA_W'(src_base[i] + src_idx[i]);
    endtask

    task automatic reset_src();
        for (int i = 0; i < 3; i++) src_idx[i] = 0;
        upd_data();
    endtask

    task automatic tick();
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) if (fire[i]) src_idx[i]++;
        upd_data();
    endtask

    int d0;

    initial begin
        reset = 1'b0; grant = 3'b000; req_valid = 3'b000; out_ready = 1'b0;
        reset_src();
        repeat (3) tick();
        chk("rst_owner", owner, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        reset = 1'b1;
        repeat (2) tick();

        // Basic burst on requester 1
        cap.delete(); d0 = done_cnt; reset_src();
        grant = 3'b010; req_valid = 3'b010; out_ready = 1'b1;
        tick();
        grant = 3'b000;
        repeat (7) tick();
        chk("basic_n", cap.size(), 4);
        for (int k = 0; k < 4 && k < cap.size(); k++) chk("basic_beat", cap[k], 8'h11 + k);
        chk("basic_done", done_cnt - d0, 1);
        chk("basic_abort", last_abort, 1'b0);
        chk("basic_owner", last_owner, 3'b010);
        chk("basic_busy_end", busy, 1'b0);

        // Grant moves to requester 2 after beat 2 of requester 0
        cap.delete(); d0 = done_cnt; reset_src();
        grant = 3'b001; req_valid = 3'b101; out_ready = 1'b1;
        tick();
        repeat (2) tick();
        grant = 3'b100;
        for (int k = 0; k < 20 && owner != 3'b100; k++) begin
            chk("gc_r2_ready", req_ready[2], 1'b0);
            tick();
        end
        chk("gc_owner2", owner, 3'b100);
        grant = 3'b000;
        repeat (6) tick();
        chk("gc_n", cap.size(), 8);
        for (int k = 0; k < 4 && k < cap.size(); k++) chk("gc_beat_r0", cap[k], 8'h01 + k);
        for (int k = 4; k < 8 && k < cap.size(); k++) chk("gc_beat_r2", cap[k], 8'h21 + k - 4);
        chk("gc_done", done_cnt - d0, 2);

        // Backpressure: sink ready alternates
        cap.delete(); d0 = done_cnt; reset_src();
        grant = 3'b001; req_valid = 3'b001; out_ready = 1'b1;
        tick();
        grant = 3'b000;
        for (int k = 0; k < 12; k++) begin
            out_ready = (k % 2 == 0);
            tick();
        end
        chk("bp_n", cap.size(), 4);
        for (int k = 0; k < 4 && k < cap.size(); k++) chk("bp_beat", cap[k], 8'h01 + k);
        chk("bp_done", done_cnt - d0, 1);
        chk("bp_abort", last_abort, 1'b0);

        // Timeout after one beat
        cap.delete(); d0 = done_cnt; reset_src();
        grant = 3'b010; req_valid = 3'b010; out_ready = 1'b1;
        tick();
        grant = 3'b000;
        tick();
        req_valid = 3'b000;
        repeat (20) tick();
        req_valid = 3'b010;
        repeat (3) tick();
        chk("to_n", cap.size(), 1);
        if (cap.size() > 0) chk("to_beat", cap[0], 8'h11);
        chk("to_done", done_cnt - d0, 1);
        chk("to_abort", last_abort, 1'b1);
        chk("to_owner", last_owner, 3'b010);

        // Non-one-hot grant in idle
        req_valid = 3'b011; d0 = gerr_cnt;
        grant = 3'b011;
        tick();
        grant = 3'b000;
        repeat (2) tick();
        chk("bad_gerr", gerr_cnt - d0, 1);
        chk("bad_busy", busy, 1'b0);
        chk("bad_owner", owner, 3'b000);

        // Reset mid-burst
        cap.delete(); d0 = done_cnt; reset_src();
        grant = 3'b100; req_valid = 3'b100; out_ready = 1'b1;
        tick();
        grant = 3'b000;
        tick();
        chk("mid_busy_pre", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_owner", owner, 3'b000);
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_req_ready", req_ready, 3'b000);
        chk("mid_out_data", out_data, 8'h00);
        repeat (2) tick();
        reset = 1'b1;
        req_valid = 3'b000;
        repeat (6) tick();
        chk("mid_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
